// File: rtl/scan_slot_receiver_pkg.sv
// Constants shared by both ends of the digit-scan link: slot address width,
// the scan order table and the receiver state encoding.
package scan_link_pkg;

    localparam int SLOT_ADDR_W = 4;
    localparam int SEQ_LEN     = 10;

    typedef logic [SLOT_ADDR_W-1:0] slot_addr_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } rx_state_e;

    // Scan order 0,9,1,2,...,8; positions past the end of the table read as 0.
    function automatic slot_addr_t seq_at(input logic [3:0] pos);
        slot_addr_t a;
        if (pos == 4'd0) begin
            a = '0;
        end else if (pos == 4'd1) begin
            a = slot_addr_t'(9);
        end else if (pos < 4'(SEQ_LEN)) begin
            a = pos - 4'd1;
        end else begin
            a = '0;
        end
        return a;
    endfunction

endpackage

// File: rtl/scan_slot_receiver_if.sv
// Link-side and read-port signals of the slot receiver; master drives the
// link and read select, slave is the receiver.
interface scan_slot_receiver_if
    import scan_link_pkg::*;
#(
    parameter int DATA_W = 8
);
    logic              tick;
    logic              sl;
    slot_addr_t        addr;
    logic              sdi;
    slot_addr_t        rd_sel;
    logic [DATA_W-1:0] rd_data;
    logic              wr_pulse;
    logic              frame_done;
    logic              seq_err;
    logic              len_err;
    logic              busy;

    modport master (
        output tick, sl, addr, sdi, rd_sel,
        input  rd_data, wr_pulse, frame_done, seq_err, len_err, busy
    );

    modport slave (
        input  tick, sl, addr, sdi, rd_sel,
        output rd_data, wr_pulse, frame_done, seq_err, len_err, busy
    );

endinterface

// File: rtl/scan_slot_receiver_regfile.sv
// Slot register file: one synchronous write port, one combinational read
// port that returns 0 for selects beyond the last slot.
module scan_slot_regfile
    import scan_link_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int NUM_SLOTS = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  slot_addr_t        wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  slot_addr_t        rd_sel,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] slots [NUM_SLOTS];

    // NOTE: the slots are reset on purpose - a blank display after reset is
    // part of the contract - so this is a flop array, not an inferred RAM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slots[i] <= '0;
            end
        end else if (wr_en) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (wr_addr == SLOT_ADDR_W'(i)) begin
                    slots[i] <= wr_data;
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (rd_sel == SLOT_ADDR_W'(i)) begin
                rd_data = slots[i];
            end
        end
    end

endmodule

// File: rtl/scan_slot_receiver.sv
// Receiving end of the digit-scan link: rebuilds each serial slot word,
// stores it, checks the scan order and flags complete in-order frames.
module scan_slot_receiver
    import scan_link_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int NUM_SLOTS = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    scan_slot_receiver_if.slave  bus
);

    localparam int                     CNT_W      = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]       LAST_BIT   = CNT_W'(DATA_W - 1);
    localparam logic [SLOT_ADDR_W:0]   SLOT_LIMIT = (SLOT_ADDR_W + 1)'(NUM_SLOTS);

    rx_state_e         state;
    rx_state_e         state_next;
    logic [DATA_W-1:0] shreg;
    logic [CNT_W-1:0]  bit_cnt;
    slot_addr_t        cur_addr;
    logic [3:0]        pos;
    logic [3:0]        pos_next;
    logic              seq_ok;
    logic              seq_ok_next;

    logic              wr_en;
    logic              frame_hit;
    logic              seq_bad;
    logic              len_bad;
    logic              wr_pulse_q;
    logic              frame_done_q;
    logic              seq_err_q;
    logic              len_err_q;

    logic              slot_start;
    logic              data_bit;
    logic              addr_in_range;

    assign slot_start    = bus.tick & bus.sl;
    assign data_bit      = bus.tick & ~bus.sl;
    assign addr_in_range = ({1'b0, cur_addr} < SLOT_LIMIT);

    // NOTE: clocked state uses non-blocking assignments only, so every flop
    // samples the values from before the edge regardless of block order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (slot_start) state_next = ST_SHIFT;
            ST_SHIFT:  if (data_bit && bit_cnt == LAST_BIT) state_next = ST_COMMIT;
            ST_COMMIT: state_next = slot_start ? ST_SHIFT : ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        wr_en       = 1'b0;
        frame_hit   = 1'b0;
        seq_bad     = 1'b0;
        len_bad     = 1'b0;
        pos_next    = pos;
        seq_ok_next = seq_ok;
        case (state)
            ST_SHIFT: len_bad = slot_start;
            ST_COMMIT: begin
                if (!addr_in_range) begin
                    seq_bad     = 1'b1;
                    seq_ok_next = 1'b0;
                    pos_next    = '0;
                end else begin
                    wr_en = 1'b1;
                    if (cur_addr == '0) begin
                        pos_next    = 4'd1;
                        seq_ok_next = 1'b1;
                    end else if (seq_ok && cur_addr == seq_at(pos)) begin
                        pos_next = pos + 4'd1;
                    end else begin
                        seq_bad     = 1'b1;
                        seq_ok_next = 1'b0;
                        pos_next    = '0;
                    end
                    if (!seq_bad && {1'b0, pos_next} == SLOT_LIMIT) begin
                        frame_hit = 1'b1;
                        pos_next  = '0;
                    end
                end
            end
            default: ;
        endcase
    end

    // A new SL restarts the word from any state; a partial word is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg    <= '0;
            bit_cnt  <= '0;
            cur_addr <= '0;
        end else if (slot_start) begin
            shreg    <= '0;
            bit_cnt  <= '0;
            cur_addr <= bus.addr;
        end else if (state == ST_SHIFT && data_bit) begin
            shreg <= {shreg[DATA_W-2:0], bus.sdi};
            if (bit_cnt != LAST_BIT) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos          <= '0;
            seq_ok       <= 1'b0;
            wr_pulse_q   <= 1'b0;
            frame_done_q <= 1'b0;
            seq_err_q    <= 1'b0;
            len_err_q    <= 1'b0;
        end else begin
            pos          <= pos_next;
            seq_ok       <= seq_ok_next;
            wr_pulse_q   <= wr_en;
            frame_done_q <= frame_hit;
            seq_err_q    <= seq_bad;
            len_err_q    <= len_bad;
        end
    end

    scan_slot_regfile #(
        .DATA_W    (DATA_W),
        .NUM_SLOTS (NUM_SLOTS)
    ) u_regfile (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (cur_addr),
        .wr_data (shreg),
        .rd_sel  (bus.rd_sel),
        .rd_data (bus.rd_data)
    );

    assign bus.wr_pulse   = wr_pulse_q;
    assign bus.frame_done = frame_done_q;
    assign bus.seq_err    = seq_err_q;
    assign bus.len_err    = len_err_q;
    assign bus.busy       = (state != ST_IDLE);

endmodule

// File: doc/scan_slot_receiver.md
Name: scan_slot_receiver

Overview:
- Receiving end of the digit-scan link. The scan sequencer walks a 4-bit slot address through the order 0,9,1,2,3,4,5,6,7,8, issues a one-tick SL (shift/load) strobe per slot, and serialises slot data on the following ticks.
- This block reconstructs each slot word, stores it in a slot register file, and checks the address order.
- It signals a complete, in-order frame to the display/RTC logic downstream.

Parameters:
- DATA_W, 8, serial bits per slot word (MSB first), range 2..15
- NUM_SLOTS, 10, number of slot registers, valid addresses 0..NUM_SLOTS-1

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- tick  in  1  one-clk enable marking a link tick; sl/addr/sdi are sampled only when tick=1
- sl  in  1  load strobe; tick&sl starts a slot
- addr  in  4  slot address, valid with tick&sl
- sdi  in  1  serial data bit, valid with tick&~sl
- rd_sel  in  4  read-port slot select
- rd_data  out  DATA_W  slot[rd_sel], combinational; 0 when rd_sel>=NUM_SLOTS
- wr_pulse  out  1  1-clk pulse when a slot register is written
- frame_done  out  1  1-clk pulse when the last slot of an in-order frame is written
- seq_err  out  1  1-clk pulse on an out-of-order or out-of-range address
- len_err  out  1  1-clk pulse when SL arrives before a slot word is complete
- busy  out  1  high in SHIFT or COMMIT

Behaviour:
- FSM states: IDLE, SHIFT, COMMIT. All registers clocked on posedge clk.
- Reset values:
  - state=IDLE, shreg=0, bit_cnt=0, cur_addr=0
  - all slot registers 0, pos=0, seq_ok=0
  - all pulse outputs 0, busy=0
- IDLE:
  - tick&sl: latch addr into cur_addr, clear bit_cnt and shreg, go to SHIFT.
  - tick&~sl is ignored.
  - No data bit is taken on the SL tick.
- SHIFT:
  - tick&~sl: shreg <= {shreg[DATA_W-2:0], sdi}, bit_cnt++.
  - When this is the DATA_W-th bit (bit_cnt==DATA_W-1 before the increment), go to COMMIT.
  - tick&sl: len_err pulse next clk. Discard partial word, latch the new addr, clear bit_cnt, stay in SHIFT.
  - No tick: hold.
- COMMIT (exactly one clk, independent of tick):
  - Write and flag rules:
    - If cur_addr<NUM_SLOTS: slot[cur_addr] <= shreg, wr_pulse=1.
    - If cur_addr>=NUM_SLOTS: no write, seq_err=1, seq_ok <= 0, pos <= 0.
  - Sequence check, against the constant order table SEQ[0..9] = 0,9,1,2,3,4,5,6,7,8:
    - cur_addr==0: pos <= 1, seq_ok <= 1 (frame start; always accepted).
    - Else if cur_addr==SEQ[pos] and seq_ok: pos <= pos+1.
    - Else: seq_err=1, seq_ok <= 0, pos <= 0.
  - Frame completion: if the accepted slot makes pos==NUM_SLOTS, frame_done=1 in the same clk as wr_pulse, and pos <= 0.
  - Next state: if tick&sl in this same clk, latch addr and go to SHIFT (back-to-back slots supported). Otherwise go to IDLE.
- Pulse outputs are registered: asserted the clk after the decision edge, deasserted the following clk.
- Written slot data is visible on rd_data the clk after COMMIT.
- Slot contents persist across errors; only reset clears them.
- Asynchronous reset at any time, including mid-SHIFT, returns all state to reset values immediately. The partial word is lost and no pulse is emitted.
- Simultaneous events:
  - tick&sl takes priority over sdi.
  - A read of the slot being written returns the old value in the COMMIT clk.
- Widths: bit_cnt is ceil(log2(DATA_W)) bits, with no wrap past DATA_W-1. pos is 4 bits.

Decomposition:
- Shared package scan_link_pkg:
  - state encoding
  - SEQ order table and SEQ_LEN=10
  - SLOT_ADDR_W=4
  - the same constants are consumed by the scan sequencer
- One natural sub-module: scan_slot_regfile (NUM_SLOTS x DATA_W write port and combinational read port).

Test Plan:
- Full frame, DATA_W=8, tick every 3rd clk:
  - Slots sent in order 0,9,1..8 with data 0x30+addr.
  - Expect 10 wr_pulse, one frame_done coincident with the slot-8 write, no errors.
  - rd_sel=9 returns 0x39.
- Out-of-order: addresses 0,9,2:
  - seq_err pulse after slot 2; slot[2] is still written.
  - No frame_done even after 3..8 are sent.
  - The next frame starting at 0 completes normally.
- Short word: SL, 5 data bits, then SL with addr=1:
  - len_err pulse, nothing written for the first slot.
  - The second slot with data 0xA5 writes slot[1]=0xA5.
- Out-of-range: addr=12 followed by 8 bits:
  - seq_err pulse, no wr_pulse, every slot unchanged.
- Back-to-back: tick every clk, SL arriving in the COMMIT clk:
  - Both slots are captured, two wr_pulse 9 clks apart.
- Reset asserted after 4 bits of slot 5:
  - All outputs 0 immediately and busy=0.
  - After release, a fresh full frame produces frame_done.
